// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame bit counts and bit-time computation.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned START_BITS = 1;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned STOP_BITS  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif
  localparam int unsigned FRAME_BITS = START_BITS + DATA_BITS + PARITY_BITS + STOP_BITS;

  localparam int unsigned BIT_CNT_W  = 4;
  localparam int unsigned BAUD_CNT_W = 16;

  // Clock cycles per serial bit (integer division).
  function automatic int unsigned bit_time(input int unsigned clock_freq,
                                           input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Per-bit timing tick: counts clock cycles within a serial bit and restarts on frame start.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned BIT_TIME = 5208
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic start,
  output logic tick_c
);

  localparam logic [BAUD_CNT_W-1:0] CNT_MAX = BAUD_CNT_W'(BIT_TIME - 1);

  logic [BAUD_CNT_W-1:0] cnt;

  // Held at zero while idle so the first bit always gets a full BIT_TIME.
  always_ff @(posedge clk) begin
    if (!rst_n || start || !run) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + BAUD_CNT_W'(1);
    end
  end

  assign tick_c = run && !start && (cnt == CNT_MAX);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 8N1 framing, LSB first; optional even parity with UART_TX_PARITY_EN.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned CLOCK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int unsigned BIT_TIME = bit_time(CLOCK_FREQ, BAUD_RATE);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

  uart_state_e state, state_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic tx_nxt, busy_nxt, done_nxt;
  logic accept_c, tick_c;
`ifdef UART_TX_PARITY_EN
  logic parity, parity_nxt;
`endif

  assign data_ready = rst_n && tx_en && (state == IDLE);
  assign accept_c   = data_valid && data_ready;

  uart_baud_gen #(
    .BIT_TIME(BIT_TIME)
  ) u_baud_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (state != IDLE),
    .start (accept_c),
    .tick_c(tick_c)
  );

  // Next-state logic; tx is computed one bit ahead so the line is driven from a flop.
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    tx_nxt      = tx;
    done_nxt    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_nxt  = parity;
`endif
    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (accept_c) begin
          state_nxt   = START;
          shift_nxt   = data_in;
          bit_cnt_nxt = '0;
          tx_nxt      = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_nxt  = ^data_in;
`endif
        end
      end
      START: begin
        if (tick_c) begin
          state_nxt = DATA;
          tx_nxt    = shift[0];
        end
      end
      DATA: begin
        if (tick_c) begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
            state_nxt   = PARITY;
            tx_nxt      = parity;
`else
            state_nxt   = STOP;
            tx_nxt      = 1'b1;
`endif
          end else begin
            bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
            shift_nxt   = shift >> 1;
            tx_nxt      = shift[1];
          end
        end
      end
      PARITY: begin
        if (tick_c) begin
          state_nxt = STOP;
          tx_nxt    = 1'b1;
        end
      end
      STOP: begin
        if (tick_c) begin
          state_nxt = IDLE;
          tx_nxt    = 1'b1;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      shift   <= shift_nxt;
      bit_cnt <= bit_cnt_nxt;
      tx      <= tx_nxt;
      busy    <= busy_nxt;
      tx_done <= done_nxt;
`ifdef UART_TX_PARITY_EN
      parity  <= parity_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter against a frame-level reference model.
module tb_uart_transmitter;

  localparam int unsigned CF = 1000000;
  localparam int unsigned BR = 100000;
  localparam int BT = CF / BR;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_en;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       tx;
  logic       busy;
  logic       tx_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_transmitter #(
    .BAUD_RATE (BR),
    .CLOCK_FREQ(CF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_en     (tx_en),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference frame: bit idx of the serial frame for byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    int ones = 0;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (NBITS == 11 && idx == 9) begin
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      return (ones % 2) == 1;
    end
    return 1'b1;
  endfunction

  // Entered at a negedge; returns with data_ready high (or after a bounded wait).
  task automatic wait_ready(output int n);
    n = 0;
    #1;
    while (!data_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!data_ready) check("ready_timeout", {31'b0, data_ready}, 32'd1);
  endtask

  task automatic frame(input logic [7:0] b, input bit scramble, input bit next_valid,
                       input logic [7:0] next_b, input int drop_en_k, output int wait_n);
    data_in    = b;
    data_valid = 1'b1;
    wait_ready(wait_n);
    @(posedge clk);
    #1;
    data_valid = next_valid;
    data_in    = next_valid ? next_b : b;
    for (int k = 0; k < NBITS * BT; k++) begin
      @(negedge clk);
      check("tx", {31'b0, tx}, {31'b0, exp_bit(b, k / BT)});
      check("busy", {31'b0, busy}, 32'd1);
      check("tx_done_early", {31'b0, tx_done}, 32'd0);
      check("ready_in_frame", {31'b0, data_ready}, 32'd0);
      if (scramble) data_in = 8'($urandom);
      if (k == drop_en_k) tx_en = 1'b0;
    end
    @(negedge clk);
    check("tx_done_pulse", {31'b0, tx_done}, 32'd1);
    check("busy_end", {31'b0, busy}, 32'd0);
    check("tx_idle", {31'b0, tx}, 32'd1);
    check("ready_end", {31'b0, data_ready}, {31'b0, tx_en});
  endtask

  task automatic abort_frame(input logic [7:0] b, input int cut);
    int n;
    data_in    = b;
    data_valid = 1'b1;
    wait_ready(n);
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    for (int k = 0; k < cut; k++) begin
      @(negedge clk);
      check("tx_pre_abort", {31'b0, tx}, {31'b0, exp_bit(b, k / BT)});
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_tx", {31'b0, tx}, 32'd1);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, tx_done}, 32'd0);
    check("abort_ready", {31'b0, data_ready}, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 2 * BT; k++) begin
      @(negedge clk);
      check("post_abort_done", {31'b0, tx_done}, 32'd0);
      check("post_abort_tx", {31'b0, tx}, 32'd1);
      check("post_abort_busy", {31'b0, busy}, 32'd0);
    end
  endtask

  initial begin
    int n;
    logic [7:0] b;
    int drop;
    rst_n      = 1'b0;
    tx_en      = 1'b1;
    data_valid = 1'b0;
    data_in    = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, tx_done}, 32'd0);
    check("rst_ready", {31'b0, data_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'b0, data_ready}, 32'd1);

    frame(8'hA5, 1'b0, 1'b0, 8'h00, -1, n);
    frame(8'h03, 1'b0, 1'b0, 8'h00, -1, n);
    frame(8'h07, 1'b0, 1'b0, 8'h00, -1, n);

    // Back-to-back: second byte is accepted in the tx_done cycle.
    frame(8'h55, 1'b0, 1'b1, 8'hAA, -1, n);
    frame(8'hAA, 1'b0, 1'b0, 8'h00, -1, n);
    check("b2b_gap", 32'(n), 32'd0);

    frame(8'h3C, 1'b1, 1'b0, 8'h00, -1, n);

    // Acceptance blocked while disabled.
    tx_en      = 1'b0;
    data_valid = 1'b1;
    data_in    = 8'h99;
    repeat (50) begin
      @(negedge clk);
      check("dis_ready", {31'b0, data_ready}, 32'd0);
      check("dis_tx", {31'b0, tx}, 32'd1);
      check("dis_busy", {31'b0, busy}, 32'd0);
    end
    data_valid = 1'b0;
    tx_en      = 1'b1;
    frame(8'h99, 1'b0, 1'b0, 8'h00, 40, n);
    tx_en = 1'b1;

    abort_frame(8'hC6, 5 * BT + 3);
    frame(8'h5A, 1'b0, 1'b0, 8'h00, -1, n);

    repeat (8) begin
      b    = 8'($urandom);
      drop = ($urandom % 2 == 1) ? int'($urandom_range(0, NBITS * BT - 1)) : -1;
      frame(b, 1'($urandom % 2), 1'b0, 8'h00, drop, n);
      tx_en = 1'b1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter BAUD_RATE, default 9600, line rate in bits/s.
REQ-002 Parameter CLOCK_FREQ, default 50000000, system clock frequency in Hz.
REQ-003 Port clk  input  1  system clock; single clock domain, all logic on rising edge.
REQ-004 Port rst_n  input  1  synchronous, active-low reset.
REQ-005 Port tx_en  input  1  enables acceptance of new bytes (power gating of idle logic).
REQ-006 Port data_in  input  8  byte to transmit.
REQ-007 Port data_valid  input  1  data_in holds a byte to send.
REQ-008 Port data_ready  output  1  block can accept a byte this cycle.
REQ-009 Port tx  output  1  UART serial line, idle high.
REQ-010 Port busy  output  1  a frame is in progress.
REQ-011 Port tx_done  output  1  one-cycle pulse when a frame's stop bit completes.

Function
REQ-012 BIT_TIME SHALL be CLOCK_FREQ/BAUD_RATE (integer division); every serial bit SHALL last exactly BIT_TIME cycles.
REQ-013 Frame SHALL be: start bit (0), data_in[0] through data_in[7] LSB first, optional parity bit (REQ-024), one stop bit (1).
REQ-014 States SHALL be IDLE, START, DATA, PARITY, STOP. Transitions: IDLE->START on accept; START->DATA, DATA->DATA for 8 bits, DATA->PARITY or STOP, PARITY->STOP, each after BIT_TIME cycles; STOP->IDLE after BIT_TIME cycles.
REQ-015 data_ready SHALL be high only in IDLE with tx_en=1.
REQ-016 A byte is accepted on the edge where data_valid && data_ready; data_in SHALL be captured into an internal shift register that edge, and later changes to data_in SHALL have no effect.
REQ-017 tx SHALL go low in the cycle after acceptance; tx is registered (no combinational path from inputs).
REQ-018 busy SHALL be high from the cycle after acceptance through the last stop-bit cycle, and low in IDLE.
REQ-019 tx_done SHALL pulse in the first IDLE cycle after STOP; data_ready may be high that same cycle, so back-to-back frames have zero idle gap beyond the stop bit.
REQ-020 Deasserting tx_en mid-frame SHALL NOT abort the frame; it only blocks the next acceptance.
REQ-021 Bit counter SHALL be 4 bits; the clock counter SHALL be 16 bits and wrap to 0 at BIT_TIME-1.

Reset
REQ-022 While rst_n=0 at a rising edge: state=IDLE, tx=1, busy=0, tx_done=0, data_ready=0, counters=0, shift register=0.
REQ-023 Reset mid-frame SHALL abort the frame; tx=1 from the next cycle; no tx_done is issued.

Configuration
REQ-024 With macro UART_TX_PARITY_EN defined: a PARITY state inserts an even-parity bit (XOR of the 8 data bits), frame = 11*BIT_TIME cycles. Without it: PARITY is unreachable, frame = 10*BIT_TIME cycles.

Structure
REQ-025 Shared package uart_pkg SHALL hold the state encodings, frame bit counts, and the BIT_TIME computation, for reuse by the receiver.
REQ-026 Sub-module uart_baud_gen SHALL produce the per-bit timing tick (counter, restart on frame start); the FSM and shift register stay in uart_transmitter.

Verification (CLOCK_FREQ=1000000, BAUD_RATE=100000, BIT_TIME=10)
REQ-027 Send 0xA5 with parity off -> tx pattern 0,1,0,1,0,0,1,0,1,1, each held 10 cycles; tx_done 100 cycles after the first start-bit cycle.
REQ-028 Send 0x03 with UART_TX_PARITY_EN -> parity bit 0, frame 110 cycles; send 0x07 -> parity bit 1.
REQ-029 Hold data_valid=1 with 0x55 then 0xAA -> second start bit begins the cycle after tx_done; no extra idle cycles.
REQ-030 Assert rst_n=0 during data bit 4 -> tx=1, busy=0 next cycle; no tx_done; next byte transmits correctly.
REQ-031 tx_en=0 with data_valid=1 -> data_ready=0, tx stays 1 for 50 cycles; drop tx_en mid-frame -> frame completes.
REQ-032 Change data_in every cycle after acceptance of 0x3C -> serialized bits still 0x3C.
